// File: rtl/systolic_tile_sequencer.sv
// Multi-tile command sequencer for the systolic array.
// A command covers row_tiles x col_tiles output tiles. For each tile, in
// row-major order, the block issues the activation, weight and output
// requests, starts the array, waits for completion and for the writer to
// flush. It then returns one response per command.
// Optional build macro SYSTOLIC_SEQ_PERF_EN adds the resp_0_cycles latency
// counter output. Without it the port and counter are absent.
module systolic_tile_sequencer #(
    parameter int SYSTOLIC_ARRAY_DIM = 8,
    parameter int DATA_WIDTH_BITS    = 16,
    parameter int TILE_BITS          = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_0_valid,
    output logic                 cmd_0_ready,
    input  logic [63:0]          cmd_0_act_addr,
    input  logic [63:0]          cmd_0_wgt_addr,
    input  logic [63:0]          cmd_0_out_addr,
    input  logic [19:0]          cmd_0_inner_dimension,
    input  logic [TILE_BITS-1:0] cmd_0_row_tiles,
    input  logic [TILE_BITS-1:0] cmd_0_col_tiles,
    output logic                 resp_0_valid,
    input  logic                 resp_0_ready,
    output logic                 weights_req_valid,
    input  logic                 weights_req_ready,
    output logic [33:0]          weights_req_len,
    output logic [63:0]          weights_req_addr_address,
    output logic                 activations_req_valid,
    input  logic                 activations_req_ready,
    output logic [33:0]          activations_req_len,
    output logic [63:0]          activations_req_addr_address,
    output logic                 vec_out_req_valid,
    input  logic                 vec_out_req_ready,
    output logic [33:0]          vec_out_req_len,
    output logic [63:0]          vec_out_req_addr_address,
    input  logic                 write_isFlushed_0_0,
    output logic                 sa_start,
    output logic [19:0]          sa_inner_dimension,
    input  logic                 sa_idle
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]          resp_0_cycles
`endif
);

    localparam int          EB             = DATA_WIDTH_BITS / 8;
    // Bytes of one DIM-wide slice per unit of K; reader length is this times K.
    localparam logic [33:0] ROW_BYTES      = 34'(EB * SYSTOLIC_ARRAY_DIM);
    localparam logic [33:0] TILE_OUT_LEN   = 34'(EB * SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM);
    localparam logic [63:0] TILE_OUT_BYTES = 64'(EB * SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_START,
        S_RUN,
        S_FLUSH,
        S_NEXT,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // Running tile addresses: stepping by L or O avoids wide multipliers,
    // and 64-bit adders wrap naturally mod 2^64.
    logic [63:0]          r_act_addr;
    logic [63:0]          r_wgt_addr;
    logic [63:0]          r_wgt_base;
    logic [63:0]          r_out_addr;
    logic [33:0]          r_len;
    logic [19:0]          r_k;
    logic [TILE_BITS-1:0] r_rows;
    logic [TILE_BITS-1:0] r_cols;
    logic [TILE_BITS-1:0] r_i;
    logic [TILE_BITS-1:0] r_j;
    logic                 r_sent_w;
    logic                 r_sent_a;
    logic                 r_sent_o;
    logic                 r_run_first;

    logic                 w_cmd_fire;
    logic                 w_zero_cmd;
    logic                 w_fire_w;
    logic                 w_fire_a;
    logic                 w_fire_o;
    logic                 w_all_sent;
    logic                 w_last_col;
    logic                 w_last_row;

    assign w_cmd_fire = (r_state == S_IDLE) && cmd_0_valid;
    assign w_zero_cmd = (cmd_0_inner_dimension == 20'd0) ||
                        (cmd_0_row_tiles == '0) || (cmd_0_col_tiles == '0);
    assign w_fire_w   = (r_state == S_ISSUE) && !r_sent_w && weights_req_ready;
    assign w_fire_a   = (r_state == S_ISSUE) && !r_sent_a && activations_req_ready;
    assign w_fire_o   = (r_state == S_ISSUE) && !r_sent_o && vec_out_req_ready;
    // A channel counts as sent if it fired earlier or fires this cycle.
    assign w_all_sent = (r_sent_w || w_fire_w) && (r_sent_a || w_fire_a) && (r_sent_o || w_fire_o);
    assign w_last_col = (r_j == r_cols - TILE_BITS'(1));
    assign w_last_row = (r_i == r_rows - TILE_BITS'(1));

    assign weights_req_len              = r_len;
    assign weights_req_addr_address     = r_wgt_addr;
    assign activations_req_len          = r_len;
    assign activations_req_addr_address = r_act_addr;
    assign vec_out_req_len              = TILE_OUT_LEN;
    assign vec_out_req_addr_address     = r_out_addr;
    assign sa_inner_dimension           = r_k;

    // State register, command latch, tile walk and per-channel sent flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_act_addr  <= '0;
            r_wgt_addr  <= '0;
            r_wgt_base  <= '0;
            r_out_addr  <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_rows      <= '0;
            r_cols      <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_sent_w    <= 1'b0;
            r_sent_a    <= 1'b0;
            r_sent_o    <= 1'b0;
            r_run_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_act_addr <= cmd_0_act_addr;
                        r_wgt_addr <= cmd_0_wgt_addr;
                        r_wgt_base <= cmd_0_wgt_addr;
                        r_out_addr <= cmd_0_out_addr;
                        r_len      <= ROW_BYTES * 34'(cmd_0_inner_dimension);
                        r_k        <= cmd_0_inner_dimension;
                        r_rows     <= cmd_0_row_tiles;
                        r_cols     <= cmd_0_col_tiles;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_sent_w   <= 1'b0;
                        r_sent_a   <= 1'b0;
                        r_sent_o   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_fire_w) r_sent_w <= 1'b1;
                    if (w_fire_a) r_sent_a <= 1'b1;
                    if (w_fire_o) r_sent_o <= 1'b1;
                end
                S_START: begin
                    // Arms the one-cycle blanking of sa_idle on RUN entry.
                    r_run_first <= 1'b1;
                end
                S_RUN: begin
                    r_run_first <= 1'b0;
                end
                S_NEXT: begin
                    r_sent_w   <= 1'b0;
                    r_sent_a   <= 1'b0;
                    r_sent_o   <= 1'b0;
                    r_out_addr <= r_out_addr + TILE_OUT_BYTES;
                    if (w_last_col) begin
                        r_j        <= '0;
                        r_i        <= r_i + TILE_BITS'(1);
                        r_act_addr <= r_act_addr + {30'd0, r_len};
                        r_wgt_addr <= r_wgt_base;
                    end else begin
                        r_j        <= r_j + TILE_BITS'(1);
                        r_wgt_addr <= r_wgt_addr + {30'd0, r_len};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next          = r_state;
        cmd_0_ready           = 1'b0;
        resp_0_valid          = 1'b0;
        weights_req_valid     = 1'b0;
        activations_req_valid = 1'b0;
        vec_out_req_valid     = 1'b0;
        sa_start              = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_0_ready = 1'b1;
                if (cmd_0_valid) begin
                    w_state_next = w_zero_cmd ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                weights_req_valid     = !r_sent_w;
                activations_req_valid = !r_sent_a;
                vec_out_req_valid     = !r_sent_o;
                if (w_all_sent) w_state_next = S_START;
            end
            S_START: begin
                if (sa_idle) begin
                    sa_start     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // The array may still report idle in the cycle right after start.
                if (!r_run_first && sa_idle) w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (write_isFlushed_0_0 && vec_out_req_ready) w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = (w_last_col && w_last_row) ? S_RESP : S_ISSUE;
            end
            S_RESP: begin
                resp_0_valid = 1'b1;
                if (resp_0_ready) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] r_cycles;

    // Command latency: first post-fire cycle counts as 1, frozen from RESP on
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_cmd_fire) begin
            r_cycles <= 32'd1;
        end else if ((r_state != S_IDLE) && (r_state != S_RESP) && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign resp_0_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: table of directed commands, a reset
// sequence and random commands, each checked against a tile-list model.
module tb_systolic_tile_sequencer;

    localparam int          DIM = 8;
    localparam int          EB  = 2;
    localparam logic [63:0] OB  = 64'(EB * DIM * DIM);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_0_valid = 1'b0;
    logic        cmd_0_ready;
    logic [63:0] cmd_0_act_addr = '0;
    logic [63:0] cmd_0_wgt_addr = '0;
    logic [63:0] cmd_0_out_addr = '0;
    logic [19:0] cmd_0_inner_dimension = '0;
    logic [7:0]  cmd_0_row_tiles = '0;
    logic [7:0]  cmd_0_col_tiles = '0;
    logic        resp_0_valid;
    logic        resp_0_ready = 1'b0;
    logic        weights_req_valid;
    logic        weights_req_ready = 1'b1;
    logic [33:0] weights_req_len;
    logic [63:0] weights_req_addr_address;
    logic        activations_req_valid;
    logic        activations_req_ready = 1'b1;
    logic [33:0] activations_req_len;
    logic [63:0] activations_req_addr_address;
    logic        vec_out_req_valid;
    logic        vec_out_req_ready = 1'b1;
    logic [33:0] vec_out_req_len;
    logic [63:0] vec_out_req_addr_address;
    logic        write_isFlushed_0_0 = 1'b1;
    logic        sa_start;
    logic [19:0] sa_inner_dimension;
    logic        sa_idle = 1'b1;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] resp_0_cycles;
`endif

    systolic_tile_sequencer dut (
        .clock                        (clock),
        .reset                        (reset),
        .cmd_0_valid                  (cmd_0_valid),
        .cmd_0_ready                  (cmd_0_ready),
        .cmd_0_act_addr               (cmd_0_act_addr),
        .cmd_0_wgt_addr               (cmd_0_wgt_addr),
        .cmd_0_out_addr               (cmd_0_out_addr),
        .cmd_0_inner_dimension        (cmd_0_inner_dimension),
        .cmd_0_row_tiles              (cmd_0_row_tiles),
        .cmd_0_col_tiles              (cmd_0_col_tiles),
        .resp_0_valid                 (resp_0_valid),
        .resp_0_ready                 (resp_0_ready),
        .weights_req_valid            (weights_req_valid),
        .weights_req_ready            (weights_req_ready),
        .weights_req_len              (weights_req_len),
        .weights_req_addr_address     (weights_req_addr_address),
        .activations_req_valid        (activations_req_valid),
        .activations_req_ready        (activations_req_ready),
        .activations_req_len          (activations_req_len),
        .activations_req_addr_address (activations_req_addr_address),
        .vec_out_req_valid            (vec_out_req_valid),
        .vec_out_req_ready            (vec_out_req_ready),
        .vec_out_req_len              (vec_out_req_len),
        .vec_out_req_addr_address     (vec_out_req_addr_address),
        .write_isFlushed_0_0          (write_isFlushed_0_0),
        .sa_start                     (sa_start),
        .sa_inner_dimension           (sa_inner_dimension),
        .sa_idle                      (sa_idle)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .resp_0_cycles                (resp_0_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] act, wgt, out;
        int          k, r, c;
        int          w_st, a_st, o_st, busy, fd, rd;
        logic [63:0] exp_act, exp_wgt, exp_out;   // last tile addresses, hand-computed
        logic [33:0] exp_lr, exp_lw;              // reader / writer lengths
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Knobs written only by the stimulus process
    int          w_stall = 0, a_stall = 0, o_stall = 0;
    int          sa_busy_len = 0, flush_delay = 0, resp_delay = 0;
    logic [19:0] cur_k = '0;
    int          clr_seq = 0;

    // State written only by the environment/monitor process
    int          clr_seen = 0;
    int          cyc = 0, n_start = 0, viol = 0, fire_cyc = -1, first_resp_cyc = -1;
    bit          in_cmd = 0, resp_done = 0;
    int          busy = 0, fl_cnt = 0, w_wait = 0, a_wait = 0, o_wait = 0, r_wait = 0;
    bit          w_pend = 0, a_pend = 0, o_pend = 0, resp_pend = 0;
    logic [97:0] w_hold, a_hold, o_hold;
    logic [63:0] q_act_a[$], q_wgt_a[$], q_out_a[$];
    logic [33:0] q_act_l[$], q_wgt_l[$], q_out_l[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    // Downstream environment (readers, writer, array) plus protocol monitor
    always @(negedge clock) begin
        bit st;
        st = sa_start;
        if (reset) begin
            busy = 0; fl_cnt = 0; w_wait = 0; a_wait = 0; o_wait = 0; r_wait = 0;
            sa_idle = 1'b1; write_isFlushed_0_0 = 1'b1; resp_0_ready = 1'b0;
            weights_req_ready = 1'b1; activations_req_ready = 1'b1; vec_out_req_ready = 1'b1;
        end else begin
            if (busy > 0) begin sa_idle = 1'b0; busy--; end else sa_idle = 1'b1;
            if (st) busy = sa_busy_len;
            if (weights_req_valid) begin
                weights_req_ready = (w_wait >= w_stall);
                if (weights_req_ready) w_wait = 0; else w_wait++;
            end else begin weights_req_ready = 1'b1; w_wait = 0; end
            if (activations_req_valid) begin
                activations_req_ready = (a_wait >= a_stall);
                if (activations_req_ready) a_wait = 0; else a_wait++;
            end else begin activations_req_ready = 1'b1; a_wait = 0; end
            if (vec_out_req_valid) begin
                vec_out_req_ready = (o_wait >= o_stall);
                if (vec_out_req_ready) o_wait = 0; else o_wait++;
            end else begin vec_out_req_ready = 1'b1; o_wait = 0; end
            if (fl_cnt > 0) begin write_isFlushed_0_0 = 1'b0; fl_cnt--; end
            else write_isFlushed_0_0 = 1'b1;
            if (resp_0_valid) begin
                resp_0_ready = (r_wait >= resp_delay);
                if (resp_0_ready) r_wait = 0; else r_wait++;
            end else begin resp_0_ready = 1'b0; r_wait = 0; end
        end
        #2;
        cyc++;
        if (clr_seq != clr_seen) begin
            clr_seen = clr_seq;
            q_act_a.delete(); q_wgt_a.delete(); q_out_a.delete();
            q_act_l.delete(); q_wgt_l.delete(); q_out_l.delete();
            n_start = 0; viol = 0; resp_done = 0; fire_cyc = -1; first_resp_cyc = -1;
        end
        if (reset) begin
            in_cmd = 0; w_pend = 0; a_pend = 0; o_pend = 0; resp_pend = 0;
        end else begin
            if (in_cmd && cmd_0_ready) viol++;
            if (cmd_0_valid && cmd_0_ready) begin in_cmd = 1; fire_cyc = cyc; end
            // Request channels: addr/len stable and valid held until fire
            if (w_pend && (!weights_req_valid || {weights_req_len, weights_req_addr_address} != w_hold)) viol++;
            if (a_pend && (!activations_req_valid || {activations_req_len, activations_req_addr_address} != a_hold)) viol++;
            if (o_pend && (!vec_out_req_valid || {vec_out_req_len, vec_out_req_addr_address} != o_hold)) viol++;
            w_pend = weights_req_valid && !weights_req_ready;
            a_pend = activations_req_valid && !activations_req_ready;
            o_pend = vec_out_req_valid && !vec_out_req_ready;
            w_hold = {weights_req_len, weights_req_addr_address};
            a_hold = {activations_req_len, activations_req_addr_address};
            o_hold = {vec_out_req_len, vec_out_req_addr_address};
            if (weights_req_valid && weights_req_ready) begin
                q_wgt_a.push_back(weights_req_addr_address); q_wgt_l.push_back(weights_req_len);
            end
            if (activations_req_valid && activations_req_ready) begin
                q_act_a.push_back(activations_req_addr_address); q_act_l.push_back(activations_req_len);
            end
            if (vec_out_req_valid && vec_out_req_ready) begin
                q_out_a.push_back(vec_out_req_addr_address); q_out_l.push_back(vec_out_req_len);
                fl_cnt = flush_delay;
            end
            // Start only with the array idle, after exactly one fire per channel for this tile
            if (sa_start) begin
                if (!sa_idle || weights_req_valid || activations_req_valid || vec_out_req_valid) viol++;
                if (q_wgt_a.size() != n_start + 1 || q_act_a.size() != n_start + 1 ||
                    q_out_a.size() != n_start + 1) viol++;
                if (sa_inner_dimension != cur_k) viol++;
                n_start++;
            end
            if (resp_pend && !resp_0_valid) viol++;
            resp_pend = resp_0_valid && !resp_0_ready;
            if (resp_0_valid && first_resp_cyc < 0) first_resp_cyc = cyc;
            if (resp_0_valid && resp_0_ready) begin resp_done = 1; in_cmd = 0; end
        end
    end

    task automatic start_cmd(input vec_t v);
        w_stall = v.w_st; a_stall = v.a_st; o_stall = v.o_st;
        sa_busy_len = v.busy; flush_delay = v.fd; resp_delay = v.rd;
        cur_k = 20'(v.k);
        clr_seq++;
        @(negedge clock);
        cmd_0_act_addr = v.act; cmd_0_wgt_addr = v.wgt; cmd_0_out_addr = v.out;
        cmd_0_inner_dimension = 20'(v.k);
        cmd_0_row_tiles = 8'(v.r); cmd_0_col_tiles = 8'(v.c);
        cmd_0_valid = 1'b1;
        #3;
        chk("cmd_ready_idle", cmd_0_ready, 1'b1);
        @(negedge clock);
        cmd_0_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits for the response, then compares everything observed with the tile model
    task automatic finish_cmd(input vec_t v, input bit is_table);
        int          n;
        logic [63:0] L, ea, ew, eo;
        for (int t = 0; t < 4000 && !resp_done; t++) begin
            @(negedge clock);
            #3;
        end
        chk("resp_seen", resp_done, 1'b1);
        if (!resp_done) do_reset(2);
        n = (v.k == 0 || v.r == 0 || v.c == 0) ? 0 : v.r * v.c;
        L = 64'(EB * DIM) * 64'(v.k);
        $display("cmd K=%0d R=%0d C=%0d act=%h wgt=%h out=%h tiles=%0d starts=%0d",
                 v.k, v.r, v.c, v.act, v.wgt, v.out, n, n_start);
        chk("n_act_req", q_act_a.size(), n);
        chk("n_wgt_req", q_wgt_a.size(), n);
        chk("n_out_req", q_out_a.size(), n);
        chk("n_sa_start", n_start, n);
        chk("protocol_violations", viol, 0);
        for (int idx = 0; idx < n; idx++) begin
            int i, j;
            i  = idx / v.c;
            j  = idx % v.c;
            ea = v.act + 64'(i) * L;
            ew = v.wgt + 64'(j) * L;
            eo = v.out + 64'(idx) * OB;
            if (idx < q_act_a.size()) chk("act_req", {q_act_l[idx], q_act_a[idx]}, {L[33:0], ea});
            if (idx < q_wgt_a.size()) chk("wgt_req", {q_wgt_l[idx], q_wgt_a[idx]}, {L[33:0], ew});
            if (idx < q_out_a.size()) chk("out_req", {q_out_l[idx], q_out_a[idx]}, {OB[33:0], eo});
        end
        if (n == 0) chk("zero_cmd_resp_latency", (first_resp_cyc - fire_cyc >= 1) && (first_resp_cyc - fire_cyc <= 2), 1'b1);
        if (is_table && n > 0 && q_act_a.size() == n && q_wgt_a.size() == n && q_out_a.size() == n) begin
            chk("last_act_addr", q_act_a[n-1], v.exp_act);
            chk("last_wgt_addr", q_wgt_a[n-1], v.exp_wgt);
            chk("last_out_addr", q_out_a[n-1], v.exp_out);
            chk("reader_len", q_act_l[0], v.exp_lr);
            chk("writer_len", q_out_l[0], v.exp_lw);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        bit   reached;
        //               act                    wgt                    out                    k        r  c  ws as os busy fd rd  exp_act                exp_wgt                exp_out                lr          lw
        tbl[0] = '{64'h0,                 64'h10000,             64'h20000,             16,      1, 1, 0, 0, 0, 20, 0, 0,  64'h0,                 64'h10000,             64'h20000,             34'd256,    34'd128};
        tbl[1] = '{64'h1000,              64'h8000,              64'h20000,             16,      2, 3, 0, 0, 0, 3,  1, 0,  64'h1100,              64'h8200,              64'h20280,             34'd256,    34'd128};
        tbl[2] = '{64'h40,                64'h80,                64'hC0,                16,      1, 1, 5, 2, 0, 4,  0, 1,  64'h40,                64'h80,                64'hC0,                34'd256,    34'd128};
        tbl[3] = '{64'h1000,              64'h2000,              64'h3000,              16,      2, 0, 0, 0, 0, 0,  0, 0,  64'h0,                 64'h0,                 64'h0,                 34'd0,      34'd0};
        tbl[4] = '{64'h1000,              64'h2000,              64'h3000,              0,       2, 2, 0, 0, 0, 0,  0, 1,  64'h0,                 64'h0,                 64'h0,                 34'd0,      34'd0};
        tbl[5] = '{64'h100,               64'h200,               64'h300,               4,       1, 2, 0, 0, 1, 2, 10, 10, 64'h100,               64'h240,               64'h380,               34'd64,     34'd128};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FF80, 16,  2, 2, 1, 0, 2, 1,  0, 0,  64'h0,                 64'hF0,                64'h100,               34'd256,    34'd128};
        tbl[7] = '{64'h0,                 64'h0,                 64'h0,                 20'hFFFFF, 1, 1, 0, 0, 0, 2,  0, 0,  64'h0,                 64'h0,                 64'h0,                 34'hFFFFF0, 34'd128};

        // Reset state, while held and after release
        repeat (3) @(negedge clock);
        #1;
        chk("reset_outputs_held", {cmd_0_ready, weights_req_valid, activations_req_valid,
                                   vec_out_req_valid, resp_0_valid, sa_start}, 6'b100000);
        reset = 1'b0;
        @(negedge clock);
        #3;
        chk("reset_outputs_released", {cmd_0_ready, weights_req_valid, activations_req_valid,
                                       vec_out_req_valid, resp_0_valid, sa_start}, 6'b100000);

        for (int t = 0; t < 8; t++) begin
            start_cmd(tbl[t]);
            finish_cmd(tbl[t], 1'b1);
            repeat (2) @(negedge clock);
        end

        // Reset during RUN of the second tile, then a clean rerun
        v = tbl[1];
        v.busy = 8;
        start_cmd(v);
        reached = 0;
        for (int t = 0; t < 2000 && !reached; t++) begin
            @(negedge clock);
            #3;
            reached = (n_start >= 2);
        end
        chk("reset_test_reached_tile2", reached, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrun_reset_outputs", {cmd_0_ready, weights_req_valid, activations_req_valid,
                                     vec_out_req_valid, resp_0_valid, sa_start}, 6'b100000);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_cmd(tbl[1]);
        finish_cmd(tbl[1], 1'b1);

        // Random commands against the tile model
        for (int t = 0; t < 12; t++) begin
            v.act  = {$urandom, $urandom};
            v.wgt  = {$urandom, $urandom};
            v.out  = {$urandom, $urandom};
            v.k    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
            v.r    = int'($urandom_range(0, 3));
            v.c    = int'($urandom_range(0, 3));
            v.w_st = int'($urandom_range(0, 3));
            v.a_st = int'($urandom_range(0, 3));
            v.o_st = int'($urandom_range(0, 3));
            v.busy = int'($urandom_range(0, 6));
            v.fd   = int'($urandom_range(0, 4));
            v.rd   = int'($urandom_range(0, 3));
            v.exp_act = '0; v.exp_wgt = '0; v.exp_out = '0; v.exp_lr = '0; v.exp_lw = '0;
            start_cmd(v);
            finish_cmd(v, 1'b0);
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
